// File: rtl/round_timer_ctrl.sv
// ---------------------------------------------------------------------------
// round_timer_ctrl
//   Game-round countdown controller. Consumes the one-cycle tick from the
//   1 Hz divider and counts the remaining seconds down from START_SEC.
//   Each wrong-answer event deducts PENALTY_SEC seconds. The remaining time
//   is also presented as BCD digits for the HEX display. The block enables
//   the divider while running and pulses its reset on every start/restart,
//   so the first second of a round is always a full second.
//
// Ports
//   clock       in   1  system clock
//   reset       in   1  synchronous, active-high
//   tick        in   1  one-cycle pulse from the 1 Hz divider
//   start       in   1  level key; a rising edge starts/restarts the round
//   pause       in   1  level key; a rising edge toggles RUN <-> PAUSED
//   penalty     in   1  level; a rising edge is one penalty event
//   div_enable  out  1  divider enable, high while in RUN
//   div_reset   out  1  one-cycle divider reload pulse on start/restart
//   secs        out  7  remaining seconds, binary 0..99
//   sec_tens    out  4  BCD tens digit of secs
//   sec_ones    out  4  BCD ones digit of secs
//   state       out  2  00 IDLE, 01 RUN, 10 PAUSED, 11 EXPIRED
//   time_up     out  1  one-cycle pulse on entry to EXPIRED
// ---------------------------------------------------------------------------
module round_timer_ctrl #(
    parameter int START_SEC   = 30,
    parameter int PENALTY_SEC = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       pause,
    input  logic       penalty,
    output logic       div_enable,
    output logic       div_reset,
    output logic [6:0] secs,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [1:0] state,
    output logic       time_up
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN     = 2'b01,
        PAUSED  = 2'b10,
        EXPIRED = 2'b11
    } state_t;

    // Saturating subtract: the remaining time bottoms out at zero and can
    // never wrap around to a large value.
    function automatic logic [6:0] sat_sub(input logic [6:0] a, input logic [7:0] d);
        if (d >= {1'b0, a}) begin
            return 7'd0;
        end
        return a - d[6:0];
    endfunction

    state_t     state_q, state_d;
    logic [6:0] secs_q, secs_d;
    logic       div_reset_q, div_reset_d;
    logic       time_up_q, time_up_d;

    // Key history; preset to 1 on reset so a key held through reset is not
    // seen as a fresh press when reset is released.
    logic       start_q, pause_q, penalty_q;
    logic       evt_start, evt_pause, evt_penalty;
    logic [7:0] dec;

    assign evt_start   = start   & ~start_q;
    assign evt_pause   = pause   & ~pause_q;
    assign evt_penalty = penalty & ~penalty_q;

    // 8 bits so a tick plus the largest penalty cannot overflow.
    assign dec = {7'd0, tick} + (evt_penalty ? 8'(PENALTY_SEC) : 8'd0);

    always_comb begin
        state_d     = state_q;
        secs_d      = secs_q;
        div_reset_d = 1'b0;
        time_up_d   = 1'b0;

        if (evt_start) begin
            // Start wins over everything else in the same cycle.
            state_d     = RUN;
            secs_d      = 7'(START_SEC);
            div_reset_d = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (evt_pause) begin
                        state_d = PAUSED;
                    end
                    // Expiry is evaluated after pause so it takes precedence.
                    if (dec >= {1'b0, secs_q}) begin
                        state_d   = EXPIRED;
                        time_up_d = 1'b1;
                    end
                    secs_d = sat_sub(secs_q, dec);
                end
                PAUSED: begin
                    if (evt_pause) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // Register stage: state, count, and one-cycle control pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            secs_q      <= 7'(START_SEC);
            div_reset_q <= 1'b0;
            time_up_q   <= 1'b0;
            start_q     <= 1'b1;
            pause_q     <= 1'b1;
            penalty_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            secs_q      <= secs_d;
            div_reset_q <= div_reset_d;
            time_up_q   <= time_up_d;
            start_q     <= start;
            pause_q     <= pause;
            penalty_q   <= penalty;
        end
    end

    assign state      = state_q;
    assign secs       = secs_q;
    assign div_reset  = div_reset_q;
    assign time_up    = time_up_q;
    assign div_enable = (state_q == RUN);
    assign sec_tens   = 4'(secs_q / 7'd10);
    assign sec_ones   = 4'(secs_q % 7'd10);

endmodule

// File: tb/tb_round_timer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_round_timer_ctrl
//   Directed-vector bench for round_timer_ctrl with a scoreboard queue.
//   Each stimulus cycle pushes the hand-computed outputs expected after the
//   next clock edge; a monitor pops one entry per cycle and compares.
// ---------------------------------------------------------------------------
module tb_round_timer_ctrl;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_PAUS = 2'b10;
    localparam logic [1:0] S_EXP  = 2'b11;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0, start = 1'b0, pause = 1'b0, penalty = 1'b0;
    logic       div_enable, div_reset, time_up;
    logic [6:0] secs;
    logic [3:0] sec_tens, sec_ones;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [1:0] st;
        int         secs;
        logic       dr;
        logic       tu;
        int         tens;   // -1 = no explicit digit check
        int         ones;
    } exp_t;

    exp_t q[$];
    exp_t e;

    round_timer_ctrl #(.START_SEC(30), .PENALTY_SEC(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .tick       (tick),
        .start      (start),
        .pause      (pause),
        .penalty    (penalty),
        .div_enable (div_enable),
        .div_reset  (div_reset),
        .secs       (secs),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .state      (state),
        .time_up    (time_up)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: one expected entry per clock edge, sampled just after it.
    always @(posedge clock) begin
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk({e.name, " state"},      int'(state),      int'(e.st));
            chk({e.name, " secs"},       int'(secs),       e.secs);
            chk({e.name, " div_reset"},  int'(div_reset),  int'(e.dr));
            chk({e.name, " time_up"},    int'(time_up),    int'(e.tu));
            chk({e.name, " div_enable"}, int'(div_enable), (e.st == S_RUN) ? 1 : 0);
            chk({e.name, " bcd value"},  int'(sec_tens) * 10 + int'(sec_ones), e.secs);
            chk({e.name, " ones<10"},    (sec_ones < 4'd10) ? 1 : 0, 1);
            if (e.tens >= 0) begin
                chk({e.name, " tens"}, int'(sec_tens), e.tens);
                chk({e.name, " ones"}, int'(sec_ones), e.ones);
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(input string name, input int r, input int tk, input int st,
                        input int pa, input int pe, input logic [1:0] est,
                        input int esecs, input int edr, input int etu);
        exp_t x;
        @(negedge clock);
        reset   = 1'(r);
        tick    = 1'(tk);
        start   = 1'(st);
        pause   = 1'(pa);
        penalty = 1'(pe);
        x.name = name;
        x.st   = est;
        x.secs = esecs;
        x.dr   = 1'(edr);
        x.tu   = 1'(etu);
        x.tens = -1;
        x.ones = -1;
        q.push_back(x);
    endtask

    task automatic bcd(input int t, input int o);
        q[$].tens = t;
        q[$].ones = o;
    endtask

    initial begin
        // ---- 1: reset, start, full countdown by ticks ----
        step("reset0",     1, 0, 0, 0, 0, S_IDLE, 30, 0, 0);
        step("reset1",     1, 0, 0, 0, 0, S_IDLE, 30, 0, 0);
        bcd(3, 0);
        step("idle",       0, 0, 0, 0, 0, S_IDLE, 30, 0, 0);
        step("idle_tick",  0, 1, 0, 0, 0, S_IDLE, 30, 0, 0);
        step("idle_pause", 0, 0, 0, 1, 0, S_IDLE, 30, 0, 0);
        step("start",      0, 0, 1, 0, 0, S_RUN,  30, 1, 0);
        step("start_hold", 0, 0, 1, 0, 0, S_RUN,  30, 0, 0);
        for (int i = 1; i <= 29; i++) begin
            step("count", 0, 1, 0, 0, 0, S_RUN, 30 - i, 0, 0);
        end
        step("expire_tick", 0, 1, 0, 0, 0, S_EXP, 0, 0, 1);
        bcd(0, 0);
        step("exp_hold",    0, 0, 0, 0, 0, S_EXP, 0, 0, 0);
        step("exp_tick",    0, 1, 0, 0, 0, S_EXP, 0, 0, 0);
        step("exp_pause",   0, 0, 0, 1, 0, S_EXP, 0, 0, 0);
        step("exp_pen",     0, 0, 0, 0, 1, S_EXP, 0, 0, 0);

        // ---- 5a + 2: restart from EXPIRED (tick ignored), penalties ----
        step("restart_exp", 0, 1, 1, 0, 0, S_RUN, 30, 1, 0);
        for (int i = 1; i <= 25; i++) begin
            step("to5", 0, 1, 0, 0, 0, S_RUN, 30 - i, 0, 0);
        end
        step("pen_at5",   0, 0, 0, 0, 1, S_RUN, 3, 0, 0);
        step("pen_held",  0, 0, 0, 0, 1, S_RUN, 3, 0, 0);
        step("tick3",     0, 1, 0, 0, 0, S_RUN, 2, 0, 0);
        step("tick2",     0, 1, 0, 0, 0, S_RUN, 1, 0, 0);
        step("pen_at1",   0, 0, 0, 0, 1, S_EXP, 0, 0, 1);
        step("pen_after", 0, 0, 0, 0, 0, S_EXP, 0, 0, 0);

        // ---- 3: tick and penalty together ----
        step("start3", 0, 0, 1, 0, 0, S_RUN, 30, 1, 0);
        for (int i = 1; i <= 20; i++) begin
            step("to10", 0, 1, 0, 0, 0, S_RUN, 30 - i, 0, 0);
        end
        step("tp_at10", 0, 1, 0, 0, 1, S_RUN, 7, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            step("to3", 0, 1, 0, 0, 0, S_RUN, 7 - i, 0, 0);
        end
        step("tp_at3",  0, 1, 0, 0, 1, S_EXP, 0, 0, 1);
        step("tp_done", 0, 0, 0, 0, 0, S_EXP, 0, 0, 0);

        // ---- 4: pause / resume ----
        step("start4", 0, 0, 1, 0, 0, S_RUN, 30, 1, 0);
        for (int i = 1; i <= 10; i++) begin
            step("to20", 0, 1, 0, 0, 0, S_RUN, 30 - i, 0, 0);
        end
        step("pause20", 0, 0, 0, 1, 0, S_PAUS, 20, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            step("paused_tick", 0, 1, 0, 0, 0, S_PAUS, 20, 0, 0);
        end
        step("paused_pen",  0, 0, 0, 0, 1, S_PAUS, 20, 0, 0);
        step("paused_idle", 0, 0, 0, 0, 0, S_PAUS, 20, 0, 0);
        step("resume",      0, 0, 0, 1, 0, S_RUN,  20, 0, 0);
        step("resume_tick", 0, 1, 0, 0, 0, S_RUN,  19, 0, 0);
        step("pause_tick",  0, 1, 0, 1, 0, S_PAUS, 18, 0, 0);
        step("pause_rel",   0, 0, 0, 0, 0, S_PAUS, 18, 0, 0);
        step("resume2",     0, 0, 0, 1, 0, S_RUN,  18, 0, 0);

        // ---- 5b: restart mid-RUN at 12, tick in same cycle ignored ----
        for (int i = 1; i <= 6; i++) begin
            step("to12", 0, 1, 0, 0, 0, S_RUN, 18 - i, 0, 0);
        end
        step("restart12", 0, 1, 1, 0, 0, S_RUN, 30, 1, 0);
        step("after_rs",  0, 0, 0, 0, 0, S_RUN, 30, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            step("to27", 0, 1, 0, 0, 0, S_RUN, 30 - i, 0, 0);
        end
        bcd(2, 7);

        // ---- 6: reset mid-round at 4, start held through reset ----
        for (int i = 1; i <= 23; i++) begin
            step("to4", 0, 1, 0, 0, 0, S_RUN, 27 - i, 0, 0);
        end
        step("reset_at4",  1, 1, 0, 0, 0, S_IDLE, 30, 0, 0);
        step("reset_hold", 1, 0, 1, 0, 0, S_IDLE, 30, 0, 0);
        step("rel_held",   0, 0, 1, 0, 0, S_IDLE, 30, 0, 0);
        step("held_more",  0, 1, 1, 0, 0, S_IDLE, 30, 0, 0);
        step("start_rel",  0, 0, 0, 0, 0, S_IDLE, 30, 0, 0);

        // ---- expiry beats a simultaneous pause ----
        step("start7", 0, 0, 1, 0, 0, S_RUN, 30, 1, 0);
        for (int i = 1; i <= 28; i++) begin
            step("to2", 0, 1, 0, 0, 0, S_RUN, 30 - i, 0, 0);
        end
        step("pause_pen_at2", 0, 0, 0, 1, 1, S_EXP, 0, 0, 1);
        step("final",         0, 0, 0, 0, 0, S_EXP, 0, 0, 0);

        // Let the monitor drain the scoreboard, bounded.
        for (int i = 0; i < 10 && q.size() != 0; i++) begin
            @(posedge clock);
            #2;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d expected=0 entries left", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
